tick_ctrl: RTL and testbench
============================

TICK_CTRL -- requirements
Module: tick_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 125000000, meaning the board clock frequency in Hz.
REQ-002 SHALL have parameter DEFAULT_FREQ, default 8, meaning the output frequency in Hz after reset.
REQ-003 SHALL have parameter CNT_W, default 32, meaning the counter and config width.
REQ-004 SHALL have port board_clk, input, 1 bit: the single clock; all logic is posedge board_clk.
REQ-005 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: request to begin generating clk_out.
REQ-007 SHALL have port stop, input, 1 bit: request to end generation cleanly.
REQ-008 SHALL have port cfg_valid, input, 1 bit: a new half-period value is offered.
REQ-009 SHALL have port cfg_half, input, CNT_W bits: half-period in board_clk cycles, minus 1.
REQ-010 SHALL have port cfg_ready, output, 1 bit: a config is accepted when cfg_valid && cfg_ready.
REQ-011 SHALL have port clk_out, output, 1 bit: the divided square wave (a logic signal, not a clock net).
REQ-012 SHALL have port tick, output, 1 bit: a one-cycle pulse on every clk_out toggle.
REQ-013 SHALL have port running, output, 1 bit: high in states RUN and STOPPING.

Function
REQ-014 SHALL implement states IDLE, RUN and STOPPING.
REQ-015 In IDLE, start SHALL move to RUN and clear count; start in RUN or STOPPING SHALL be ignored.
REQ-016 In RUN, count SHALL increment by 1 per cycle.
- When count == half_reg: count SHALL go to 0, clk_out SHALL toggle and tick SHALL be 1 on the same edge.
- Period = 2*(half_reg+1) cycles.
REQ-017 The first clk_out toggle SHALL occur half_reg+1 cycles after the start edge; clk_out SHALL start low.
REQ-018 stop in RUN SHALL move to STOPPING; STOPPING SHALL return to IDLE at the first terminal count that drives clk_out low.
- If clk_out is already low, it SHALL instead wait for the terminal count after the next high phase.
- No shortened high pulse SHALL ever be produced.
REQ-019 stop in IDLE SHALL be ignored; start and stop in the same IDLE cycle SHALL leave the block in IDLE.
REQ-020 cfg_ready SHALL be 1 in IDLE and 1 in RUN when no config is pending; it SHALL be 0 in STOPPING and while a config is pending.
REQ-021 An accepted config in IDLE SHALL load half_reg immediately.
- cfg accepted together with start SHALL be used by that start.
REQ-022 An accepted config in RUN SHALL be held as pending and loaded into half_reg at the next terminal count; cfg_ready SHALL return to 1 the cycle after that load.
REQ-023 cfg_half = 0 SHALL be legal and give a toggle (and tick) every cycle.
REQ-024 Count compare SHALL be equality on CNT_W bits; count SHALL never exceed half_reg.

Reset
REQ-025 On rstn low, the following SHALL happen immediately, independent of board_clk:
- state = IDLE, count = 0, clk_out = 0, tick = 0, pending cleared, cfg_ready = 1.
- half_reg = CLK_HZ/(2*DEFAULT_FREQ)-1 (7812499 at defaults).
REQ-026 Reset asserted mid-period or mid-STOPPING SHALL abort with no further tick.

Configuration
REQ-027 With TICK_CTRL_CNT_EN defined, the block SHALL add:
- output tick_cnt, 16 bits: increments on each tick, wraps 0xFFFF->0, reset 0, cleared on start.
- input tick_cnt_clr, 1 bit: clears tick_cnt; a clear takes priority over a same-cycle increment.
REQ-028 Without TICK_CTRL_CNT_EN, these ports and their logic SHALL be absent.

Structure
REQ-029 Package tick_ctrl_pkg SHALL hold the state enum type tick_state_t and the default CLK_HZ and DEFAULT_FREQ constants.
REQ-030 The counter SHALL be a sub-module half_period_cnt (ports: enable, clear, limit; output: terminal).

Verification
REQ-031 Reset, then cfg_half=3 in IDLE, then start -> clk_out toggles every 4 cycles, first toggle 4 cycles after start, tick coincident with each toggle.
REQ-032 cfg_half=1 offered mid-high-phase while running at 3 -> cfg_ready drops; the new period of 4 cycles starts exactly at the next terminal count; no runt pulse.
REQ-033 stop while clk_out high -> IDLE reached on the falling toggle; running deasserts; clk_out stays 0 afterwards.
REQ-034 cfg_half=0 -> clk_out toggles every cycle and tick is held high; start+stop in the same IDLE cycle -> remains IDLE.
REQ-035 rstn pulsed low mid-period -> all outputs take reset values asynchronously; half_reg equals 7812499 (checked via a short-CLK_HZ build: CLK_HZ=16, DEFAULT_FREQ=2 -> half=3).
REQ-036 With TICK_CTRL_CNT_EN: 65537 ticks -> tick_cnt = 1; tick_cnt_clr on a tick cycle -> tick_cnt = 0.

Source files
------------

// File: rtl/tick_ctrl_pkg.sv
// Shared types and defaults for the tick_ctrl clock divider.
package tick_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } tick_state_t;

  localparam int unsigned DEF_CLK_HZ   = 125_000_000;
  localparam int unsigned DEF_OUT_FREQ = 8;

  // Half-period minus one for a given board clock and output frequency.
  function automatic longint unsigned reset_half(input longint unsigned clk_hz,
                                                 input longint unsigned freq);
    return clk_hz / (2 * freq) - 1;
  endfunction

endpackage

// File: rtl/tick_ctrl_half_period_cnt.sv
// Half-period up-counter: wraps to zero and flags terminal when count reaches limit.
module half_period_cnt
  import tick_ctrl_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         board_clk,
  input  logic         rstn,
  input  logic         enable,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         terminal
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    terminal = enable && !clear && (count_q == limit);
    count_d  = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = terminal ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge board_clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tick_ctrl.sv
// Programmable square-wave generator with clean stop and glitch-free reconfiguration.
// Optional tick counter enabled by defining TICK_CTRL_CNT_EN.
//
// state       | meaning
// ST_IDLE     | clk_out held low, config loads directly into half register
// ST_RUN      | dividing; new config parked as pending until the next terminal count
// ST_STOPPING | still dividing; exits on the terminal count that drives clk_out low
module tick_ctrl
  import tick_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ       = DEF_CLK_HZ,
  parameter int unsigned DEFAULT_FREQ = DEF_OUT_FREQ,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             board_clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             running
`ifdef TICK_CTRL_CNT_EN
  ,
  input  logic             tick_cnt_clr,
  output logic [15:0]      tick_cnt
`endif
);

  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(reset_half(CLK_HZ, DEFAULT_FREQ));

  tick_state_t      state_q, state_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             running_q, running_d;
  logic             cfg_ready_q, cfg_ready_d;

  logic cfg_acc;
  logic start_go;
  logic cnt_en;
  logic terminal;

  assign cfg_acc  = cfg_valid && cfg_ready_q;
  // A simultaneous stop cancels the start request.
  assign start_go = (state_q == ST_IDLE) && start && !stop;
  assign cnt_en   = (state_q != ST_IDLE);

  half_period_cnt #(
    .W(CNT_W)
  ) u_cnt (
    .board_clk (board_clk),
    .rstn      (rstn),
    .enable    (cnt_en),
    .clear     (start_go),
    .limit     (half_q),
    .terminal  (terminal)
  );

  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_acc) begin
          half_d = cfg_half;
        end
        if (start_go) begin
          state_d   = ST_RUN;
          clk_out_d = 1'b0;
        end
      end
      ST_RUN, ST_STOPPING: begin
        if (cfg_acc) begin
          pend_d     = 1'b1;
          pend_val_d = cfg_half;
        end
        if (terminal) begin
          clk_out_d = ~clk_out_q;
          tick_d    = 1'b1;
          if (pend_q) begin
            half_d = pend_val_q;
            pend_d = 1'b0;
          end
        end
        if (state_q == ST_RUN) begin
          if (stop) begin
            state_d = ST_STOPPING;
          end
        end else if (terminal && clk_out_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clk_out_d = 1'b0;
        pend_d    = 1'b0;
      end
    endcase

    running_d   = (state_d != ST_IDLE);
    cfg_ready_d = (state_d == ST_IDLE) || ((state_d == ST_RUN) && !pend_d);
  end

  always_ff @(posedge board_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      half_q      <= HALF_RST;
      pend_q      <= 1'b0;
      pend_val_q  <= '0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
      running_q   <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      pend_q      <= pend_d;
      pend_val_q  <= pend_val_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
      running_q   <= running_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign clk_out   = clk_out_q;
  assign tick      = tick_q;
  assign running   = running_q;
  assign cfg_ready = cfg_ready_q;

`ifdef TICK_CTRL_CNT_EN
  logic [15:0] tick_cnt_q, tick_cnt_d;

  // Counts completed tick cycles; clear beats start beats increment.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (tick_cnt_clr || start_go) begin
      tick_cnt_d = '0;
    end else if (tick_q) begin
      tick_cnt_d = tick_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge board_clk or negedge rstn) begin
    if (!rstn) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign tick_cnt = tick_cnt_q;
`endif

endmodule

// File: tb/tb_tick_ctrl.sv
// Directed scoreboard bench for tick_ctrl (short build: CLK_HZ=16, DEFAULT_FREQ=2 -> reset half = 3).
module tb_tick_ctrl;

  localparam int unsigned CNT_W = 32;

  logic             board_clk = 1'b0;
  logic             rstn      = 1'b1;
  logic             start     = 1'b0;
  logic             stop      = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_half  = '0;
  logic             cfg_ready;
  logic             clk_out;
  logic             tick;
  logic             running;
`ifdef TICK_CTRL_CNT_EN
  logic             tick_cnt_clr = 1'b0;
  logic [15:0]      tick_cnt;
`endif

  typedef struct packed {
    logic co;
    logic tk;
    logic rn;
    logic rdy;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 board_clk = ~board_clk;

  tick_ctrl #(
    .CLK_HZ       (16),
    .DEFAULT_FREQ (2),
    .CNT_W        (CNT_W)
  ) dut (
    .board_clk (board_clk),
    .rstn      (rstn),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .running   (running)
`ifdef TICK_CTRL_CNT_EN
    ,
    .tick_cnt_clr (tick_cnt_clr),
    .tick_cnt     (tick_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push n expected samples; only the first carries the given tick value.
  task automatic push_n(input int n, input logic co, input logic tk0, input logic rn, input logic rdy);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.co  = co;
      e.tk  = (i == 0) ? tk0 : 1'b0;
      e.rn  = rn;
      e.rdy = rdy;
      sb.push_back(e);
    end
  endtask

  task automatic cmp(input string tag);
    exp_t e;
    n_assert++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "/clk_out"},   {31'd0, clk_out},   {31'd0, e.co});
      check({tag, "/tick"},      {31'd0, tick},      {31'd0, e.tk});
      check({tag, "/running"},   {31'd0, running},   {31'd0, e.rn});
      check({tag, "/cfg_ready"}, {31'd0, cfg_ready}, {31'd0, e.rdy});
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge board_clk);
    #1;
    cmp(tag);
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) cyc(tag);
  endtask

  initial begin
    #1 rstn = 1'b0;
    #2;
    push_n(1, 0, 0, 0, 1);
    cmp("reset");
`ifdef TICK_CTRL_CNT_EN
    check("reset/tick_cnt", {16'd0, tick_cnt}, 32'd0);
`endif
    @(posedge board_clk);
    #1 rstn = 1'b1;
    push_n(1, 0, 0, 0, 1);
    cyc("idle");

    // Reset half-period (3) used by a start with no config.
    start = 1'b1;
    push_n(4, 0, 0, 1, 1); push_n(4, 1, 1, 1, 1); push_n(4, 0, 1, 1, 1); push_n(2, 1, 1, 1, 1);
    cyc("rst_half");
    start = 1'b0;
    run(13, "rst_half");

    // Asynchronous reset in the middle of a high phase.
    #2 rstn = 1'b0;
    #1;
    push_n(1, 0, 0, 0, 1);
    cmp("async_rst");
    push_n(2, 0, 0, 0, 1);
    run(2, "in_rst");
    rstn = 1'b1;
    push_n(2, 0, 0, 0, 1);
    run(2, "post_rst");

    // cfg_half=3 loaded in IDLE, then start.
    cfg_valid = 1'b1; cfg_half = 3;
    push_n(1, 0, 0, 0, 1);
    cyc("cfg_idle");
    cfg_valid = 1'b0;
    start = 1'b1;
    push_n(4, 0, 0, 1, 1); push_n(4, 1, 1, 1, 1); push_n(4, 0, 1, 1, 1); push_n(2, 1, 1, 1, 1);
    cyc("h3");
    start = 1'b0;
    run(13, "h3");

    // cfg_half=1 offered mid-high phase: pending until the next terminal count.
    cfg_valid = 1'b1; cfg_half = 1;
    push_n(2, 1, 0, 1, 0);
    cyc("cfg_pend");
    cfg_valid = 1'b0;
    cyc("cfg_pend");
    push_n(2, 0, 1, 1, 1); push_n(2, 1, 1, 1, 1); push_n(2, 0, 1, 1, 1);
    run(6, "h1");

    // stop while clk_out is high: exit on the falling toggle.
    push_n(1, 1, 1, 1, 1);
    cyc("h1");
    stop = 1'b1;
    push_n(1, 1, 0, 1, 0);
    cyc("stop_hi");
    stop = 1'b0;
    push_n(1, 0, 1, 0, 1); push_n(3, 0, 0, 0, 1);
    run(4, "stop_hi");

    // Config with start (half=2), then stop while low; start/cfg ignored while stopping.
    cfg_valid = 1'b1; cfg_half = 2; start = 1'b1;
    push_n(3, 0, 0, 1, 1); push_n(3, 1, 1, 1, 1); push_n(1, 0, 1, 1, 1);
    cyc("h2");
    cfg_valid = 1'b0; start = 1'b0;
    run(6, "h2");
    stop = 1'b1;
    push_n(2, 0, 0, 1, 0);
    cyc("stop_lo");
    stop = 1'b0; start = 1'b1; cfg_valid = 1'b1; cfg_half = 0;
    cyc("stop_lo");
    push_n(3, 1, 1, 1, 0);
    run(3, "stop_lo");
    start = 1'b0; cfg_valid = 1'b0;
    push_n(1, 0, 1, 0, 1); push_n(2, 0, 0, 0, 1);
    run(3, "stop_lo");

    // cfg_half=0: toggle and tick every cycle.
    cfg_valid = 1'b1; cfg_half = 0; start = 1'b1;
    push_n(1, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) push_n(1, (i % 2 == 0), 1, 1, 1);
    cyc("h0");
    cfg_valid = 1'b0; start = 1'b0;
    run(6, "h0");
    stop = 1'b1;
    push_n(1, 1, 1, 1, 0);
    cyc("h0_stop");
    stop = 1'b0;
    push_n(1, 0, 1, 0, 1); push_n(2, 0, 0, 0, 1);
    run(3, "h0_stop");

    // start and stop together in IDLE stays idle.
    start = 1'b1; stop = 1'b1;
    push_n(1, 0, 0, 0, 1);
    cyc("start_stop");
    start = 1'b0; stop = 1'b0;
    push_n(2, 0, 0, 0, 1);
    run(2, "start_stop");

`ifdef TICK_CTRL_CNT_EN
    begin
      int seen;
      int budget;
      seen   = 0;
      budget = 0;
      start = 1'b1;
      @(posedge board_clk);
      #1 start = 1'b0;
      check("tc_start", {16'd0, tick_cnt}, 32'd0);
      while (seen < 65537 && budget < 70000) begin
        @(posedge board_clk);
        #1;
        budget++;
        if (tick) seen++;
      end
      check("tc_budget", seen, 32'd65537);
      @(posedge board_clk);
      #1;
      check("tc_wrap", {16'd0, tick_cnt}, 32'(seen % 65536));
      tick_cnt_clr = 1'b1;
      @(posedge board_clk);
      #1 tick_cnt_clr = 1'b0;
      check("tc_clr", {16'd0, tick_cnt}, 32'd0);
      @(posedge board_clk);
      #1;
      check("tc_after_clr", {16'd0, tick_cnt}, 32'd1);
    end
`endif

    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
